// File: rtl/vpu_clk_switch_ctrl.sv
// vpu_clk_switch_ctrl
//   Drives the vpu clock divider and changes its divide ratio without glitches.
//   A new setting first drains to the end of the current low phase. The output is
//   then held low for QUIESCE_CYC cycles, the new ratio is loaded, and the output
//   stays low for SETTLE_CYC more cycles. After that the clock restarts, or stays
//   off if the new setting disables it.
//
// Ports
//   CRCU_CLK        source clock, sole clock domain
//   CRCU_RST_N      asynchronous active-low reset
//   cfg_valid       one-cycle strobe, control register written
//   cfg_sel[2:0]    frequency select (000:/12, 001:/3, 010:/2, others rejected)
//   cfg_clk_en      clock enable
//   cfg_gate        clock gate (1 = gated)
//   cfg_ready       a new config can be accepted (OFF or RUN)
//   vpu_clk         registered divided clock
//   vpu_clk_active  high while in RUN
//   cur_sel[2:0]    select currently applied
//   switch_done     one-cycle pulse in the first cycle after a switch
//   cfg_err         one-cycle pulse after an unsupported select is accepted
module vpu_clk_switch_ctrl #(
  parameter int unsigned QUIESCE_CYC = 4,
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       CRCU_CLK,
  input  logic       CRCU_RST_N,
  input  logic       cfg_valid,
  input  logic [2:0] cfg_sel,
  input  logic       cfg_clk_en,
  input  logic       cfg_gate,
  output logic       cfg_ready,
  output logic       vpu_clk,
  output logic       vpu_clk_active,
  output logic [2:0] cur_sel,
  output logic       switch_done,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    S_OFF,
    S_RUN,
    S_DRAIN,
    S_QUIESCE,
    S_SETTLE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_last, cnt_half;
  logic [3:0]       phase, phase_nxt;
  logic [2:0]       lat_sel;
  logic             lat_en, lat_gate;
  logic             accept, sel_ok, take;
  logic             q_last, s_last, run_ok;
  logic             vpu_clk_nxt;

  assign accept = cfg_valid && cfg_ready;
  assign sel_ok = (cfg_sel <= 3'd2);
  assign take   = accept && sel_ok;
  assign q_last = (phase == 4'(QUIESCE_CYC - 1));
  assign s_last = (phase == 4'(SETTLE_CYC - 1));
  assign run_ok = lat_en && !lat_gate;

  // The divide ratio comes from the applied select. It changes only in QUIESCE,
  // where the output is held low anyway.
  always_comb begin
    cnt_last = CNT_W'(11);
    cnt_half = CNT_W'(6);
    case (cur_sel)
      3'b001: begin
        cnt_last = CNT_W'(2);
        cnt_half = CNT_W'(1);
      end
      3'b010: begin
        cnt_last = CNT_W'(1);
        cnt_half = CNT_W'(1);
      end
      default: begin
        cnt_last = CNT_W'(11);
        cnt_half = CNT_W'(6);
      end
    endcase
  end

  // State register
  always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
    if (!CRCU_RST_N) state <= S_OFF;
    else             state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF:     if (take) state_nxt = S_QUIESCE;
      S_RUN:     if (take) state_nxt = S_DRAIN;
      S_DRAIN:   if (cnt == cnt_last) state_nxt = S_QUIESCE;
      S_QUIESCE: if (q_last) state_nxt = S_SETTLE;
      S_SETTLE:  if (s_last) state_nxt = run_ok ? S_RUN : S_OFF;
      default:   state_nxt = S_OFF;
    endcase
  end

  // Output logic decoded from the state
  always_comb begin
    cfg_ready      = (state == S_OFF) || (state == S_RUN);
    vpu_clk_active = (state == S_RUN);
  end

  // The counter and clock for the next cycle are computed together. This lets
  // vpu_clk be a flop that already matches cnt in the first cycle of RUN.
  always_comb begin
    cnt_nxt   = cnt;
    phase_nxt = '0;
    case (state)
      S_RUN, S_DRAIN: cnt_nxt = (cnt == cnt_last) ? '0 : cnt + CNT_W'(1);
      S_QUIESCE: begin
        phase_nxt = q_last ? '0 : phase + 4'd1;
        if (q_last) cnt_nxt = '0;
      end
      S_SETTLE: phase_nxt = s_last ? '0 : phase + 4'd1;
      default: begin
        cnt_nxt   = cnt;
        phase_nxt = '0;
      end
    endcase
    vpu_clk_nxt = ((state_nxt == S_RUN) || (state_nxt == S_DRAIN)) && (cnt_nxt < cnt_half);
  end

  always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
    if (!CRCU_RST_N) begin
      cnt         <= '0;
      phase       <= '0;
      vpu_clk     <= 1'b0;
      cur_sel     <= '0;
      lat_sel     <= '0;
      lat_en      <= 1'b0;
      lat_gate    <= 1'b0;
      switch_done <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      phase       <= phase_nxt;
      vpu_clk     <= vpu_clk_nxt;
      switch_done <= (state == S_SETTLE) && s_last;
      cfg_err     <= accept && !sel_ok;
      if (take) begin
        lat_sel  <= cfg_sel;
        lat_en   <= cfg_clk_en;
        lat_gate <= cfg_gate;
      end
      if ((state == S_QUIESCE) && q_last) cur_sel <= lat_sel;
    end
  end

endmodule

// File: tb/tb_vpu_clk_switch_ctrl.sv
// tb_vpu_clk_switch_ctrl
//   Checks every cycle against a cycle-number model. The model computes the
//   expected clock waveform and the switch milestones (drain end, load cycle,
//   done cycle) from absolute cycle arithmetic. Directed scenarios run first,
//   followed by random configuration traffic.
module tb_vpu_clk_switch_ctrl;

  localparam int Q = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic [2:0] cfg_sel;
  logic       cfg_clk_en;
  logic       cfg_gate;
  logic       cfg_ready;
  logic       vpu_clk;
  logic       vpu_clk_active;
  logic [2:0] cur_sel;
  logic       switch_done;
  logic       cfg_err;

  vpu_clk_switch_ctrl #(.QUIESCE_CYC(Q), .SETTLE_CYC(S), .CNT_W(4)) dut (
    .CRCU_CLK      (clk),
    .CRCU_RST_N    (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_sel       (cfg_sel),
    .cfg_clk_en    (cfg_clk_en),
    .cfg_gate      (cfg_gate),
    .cfg_ready     (cfg_ready),
    .vpu_clk       (vpu_clk),
    .vpu_clk_active(vpu_clk_active),
    .cur_sel       (cur_sel),
    .switch_done   (switch_done),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: mode 0 = off, 1 = running, 2 = switching
  int         m_mode;
  logic [2:0] m_sel;
  int         m_rs;
  logic [2:0] m_new_sel;
  logic       m_new_run;
  logic       m_was_run;
  int         m_drain_end, m_qstart, m_load, m_done, m_err;

  function automatic int n_of(input logic [2:0] s);
    case (s)
      3'b001:  return 3;
      3'b010:  return 2;
      default: return 12;
    endcase
  endfunction

  function automatic logic pat(input int k, input int rs, input int n);
    return ((k - rs) % n) < (n / 2);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sel = 3'b000; m_rs = 0; m_new_sel = 3'b000; m_new_run = 1'b0;
    m_was_run = 1'b0; m_drain_end = -1; m_qstart = -1; m_load = -1; m_done = -1; m_err = -1;
  endtask

  task automatic check_all();
    logic       e_clk;
    logic [2:0] e_sel;
    if (m_mode == 2 && cyc == m_done) begin
      m_sel = m_new_sel;
      if (m_new_run) begin m_mode = 1; m_rs = cyc; end
      else m_mode = 0;
    end
    case (m_mode)
      1:       e_clk = pat(cyc, m_rs, n_of(m_sel));
      2:       e_clk = (m_was_run && cyc <= m_drain_end) ? pat(cyc, m_rs, n_of(m_sel)) : 1'b0;
      default: e_clk = 1'b0;
    endcase
    e_sel = (m_mode == 2 && cyc >= m_load) ? m_new_sel : m_sel;
    chk("vpu_clk", {7'd0, vpu_clk}, {7'd0, e_clk});
    chk("cfg_ready", {7'd0, cfg_ready}, {7'd0, m_mode != 2});
    chk("active", {7'd0, vpu_clk_active}, {7'd0, m_mode == 1});
    chk("cur_sel", {5'd0, cur_sel}, {5'd0, e_sel});
    chk("switch_done", {7'd0, switch_done}, {7'd0, cyc == m_done});
    chk("cfg_err", {7'd0, cfg_err}, {7'd0, cyc == m_err});
  endtask

  // Apply this cycle's inputs to the model; the effects appear from cyc+1.
  task automatic model_apply(input logic v, input logic [2:0] s, input logic e, input logic g);
    int n, p;
    if (!v || m_mode == 2) return;
    if (s > 3'd2) begin
      m_err = cyc + 1;
      return;
    end
    m_was_run = (m_mode == 1);
    if (m_mode == 1) begin
      n = n_of(m_sel);
      p = (cyc - m_rs) % n;
      m_drain_end = cyc + ((p == n - 1) ? n : (n - 1 - p));
    end else begin
      m_drain_end = cyc;
    end
    m_qstart  = m_drain_end + 1;
    m_load    = m_qstart + Q;
    m_done    = m_qstart + Q + S;
    m_new_sel = s;
    m_new_run = e && !g;
    m_mode    = 2;
  endtask

  task automatic step(input logic v, input logic [2:0] s, input logic e, input logic g);
    cfg_valid = v; cfg_sel = s; cfg_clk_en = e; cfg_gate = g;
    model_apply(v, s, e, g);
    @(posedge clk); #1;
    cyc++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic wait_settled(input int budget);
    int k = 0;
    while (m_mode == 2 && k < budget) begin
      step(1'b0, 3'b000, 1'b0, 1'b0);
      k++;
    end
    if (m_mode == 2) chk("wait_settled_timeout", 8'd1, 8'd0);
  endtask

  task automatic do_reset_release();
    cfg_valid = 1'b0; cfg_sel = '0; cfg_clk_en = 1'b0; cfg_gate = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    model_reset();
    check_all();
  endtask

  // Assert reset in the middle of a cycle. The outputs must drop right away,
  // before any clock edge.
  task automatic async_reset_check(input string tag);
    #3 rst_n = 1'b0;
    #1;
    chk({tag, "_clk"}, {7'd0, vpu_clk}, 8'd0);
    chk({tag, "_sel"}, {5'd0, cur_sel}, 8'd0);
    chk({tag, "_ready"}, {7'd0, cfg_ready}, 8'd1);
    chk({tag, "_active"}, {7'd0, vpu_clk_active}, 8'd0);
    do_reset_release();
  endtask

  initial begin
    int k;
    logic       v, e, g;
    logic [2:0] s;
    rst_n = 1'b0;
    model_reset();
    do_reset_release();

    // Idle after reset
    idle(20);

    // From OFF, sel=001: RUN begins 7 cycles after the accept
    step(1'b1, 3'b001, 1'b1, 1'b0);
    wait_settled(40);
    idle(12);

    // Switch to /12 and run for a while
    step(1'b1, 3'b000, 1'b1, 1'b0);
    wait_settled(60);
    idle(15);

    // Accept sel=010 at cnt=2 while running /12
    k = 0;
    while (!(m_mode == 1 && ((cyc - m_rs) % 12) == 2) && k < 30) begin
      step(1'b0, 3'b000, 1'b0, 1'b0);
      k++;
    end
    chk("pos2_reached", {7'd0, m_mode == 1 && ((cyc - m_rs) % 12) == 2}, 8'd1);
    step(1'b1, 3'b010, 1'b1, 1'b0);
    wait_settled(60);
    idle(10);

    // Unsupported select in RUN
    step(1'b1, 3'b101, 1'b0, 1'b1);
    idle(8);

    // Gate the clock, with an ignored strobe during QUIESCE
    step(1'b1, 3'b001, 1'b1, 1'b1);
    k = 0;
    while (cyc != m_qstart + 1 && k < 40) begin
      step(1'b0, 3'b000, 1'b0, 1'b0);
      k++;
    end
    step(1'b1, 3'b001, 1'b1, 1'b0);
    wait_settled(40);
    idle(10);

    // Reset in the middle of QUIESCE
    step(1'b1, 3'b001, 1'b1, 1'b0);
    k = 0;
    while (cyc != m_qstart + 1 && k < 20) begin
      step(1'b0, 3'b000, 1'b0, 1'b0);
      k++;
    end
    async_reset_check("rst_quiesce");
    idle(5);

    // Reset while vpu_clk is high
    step(1'b1, 3'b000, 1'b1, 1'b0);
    wait_settled(40);
    idle(2);
    chk("pre_rst_high", {7'd0, vpu_clk}, 8'd1);
    async_reset_check("rst_run");

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      v = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      e = ($urandom_range(0, 3) != 0);
      g = ($urandom_range(0, 4) == 0);
      step(v, s, e, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
